// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads the 16 words of one block, then emits W0..W63
// from a 16-word sliding window that computes each new word as the window shifts.
module sha256_msg_schedule #(
  parameter int WORD_W     = 32,
  parameter int NUM_ROUNDS = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_word,
  output logic [5:0]        out_round,
  output logic              out_last,
  output logic              busy
);

  localparam logic [0:0] LOAD = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;

  logic [0:0]        state;
  logic [3:0]        load_cnt;
  logic [5:0]        round;
  logic [WORD_W-1:0] w [16];

  logic              in_hs;
  logic              out_hs;
  logic              shift_en;
  logic              last_round;
  logic [WORD_W-1:0] sched_word;
  logic [WORD_W-1:0] new_word;

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    ssig0 = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    ssig1 = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0000000000, x[31:10]};
  endfunction

  // Handshake decode and next-word selection for the shared shift path
  always_comb begin
    in_hs      = 1'b0;
    out_hs     = 1'b0;
    new_word   = in_word;
    last_round = (round == 6'(NUM_ROUNDS - 1));
    sched_word = ssig1(w[14]) + w[9] + ssig0(w[1]) + w[0];
    case (state)
      LOAD: begin
        in_hs    = in_valid;
        new_word = in_word;
      end
      EMIT: begin
        out_hs   = out_ready;
        new_word = sched_word;
      end
      default: begin
        in_hs    = 1'b0;
        out_hs   = 1'b0;
        new_word = in_word;
      end
    endcase
    shift_en = in_hs | out_hs;
  end

  // Window shift, load counter, round counter and state transitions
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= LOAD;
      load_cnt <= 4'd0;
      round    <= 6'd0;
      for (int i = 0; i < 16; i++) w[i] <= '0;
    end else begin
      if (shift_en) begin
        for (int i = 0; i < 15; i++) w[i] <= w[i+1];
        w[15] <= new_word;
      end
      case (state)
        LOAD: begin
          if (in_hs) begin
            if (load_cnt == 4'd15) begin
              state    <= EMIT;
              load_cnt <= 4'd0;
              round    <= 6'd0;
            end else begin
              load_cnt <= load_cnt + 4'd1;
            end
          end
        end
        EMIT: begin
          if (out_hs) begin
            if (last_round) begin
              state    <= LOAD;
              load_cnt <= 4'd0;
              round    <= 6'd0;
            end else begin
              round <= round + 6'd1;
            end
          end
        end
        default: begin
          state    <= LOAD;
          load_cnt <= 4'd0;
          round    <= 6'd0;
        end
      endcase
    end
  end

  assign in_ready  = (state == LOAD);
  assign out_valid = (state == EMIT);
  assign busy      = (state == EMIT);
  assign out_word  = w[0];
  assign out_round = round;
  assign out_last  = (state == EMIT) && last_round;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Randomised directed bench for sha256_msg_schedule against an array-based
// reference of the SHA-256 message expansion.
module tb_sha256_msg_schedule;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_word = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_word;
  logic [5:0]  out_round;
  logic        out_last;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int dut_hs = 0;
  int last_cnt = 0;

  logic [31:0] blk  [16];
  logic [31:0] expw [64];

  sha256_msg_schedule #(.WORD_W(32), .NUM_ROUNDS(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_word(in_word), .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_round(out_round), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Reference expansion straight from the SHA-256 recurrence
  task automatic build_model();
    for (int t = 0; t < 16; t++) expw[t] = blk[t];
    for (int t = 16; t < 64; t++)
      expw[t] = s1(expw[t-2]) + expw[t-7] + s0(expw[t-15]) + expw[t-16];
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_abc();
    blk[0] = 32'h61626380;
    for (int i = 1; i < 15; i++) blk[i] = 32'h00000000;
    blk[15] = 32'h00000018;
  endtask

  task automatic set_ff();
    for (int i = 0; i < 16; i++) blk[i] = 32'hFFFFFFFF;
  endtask

  task automatic set_rand();
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_out_last",  32'(out_last),  32'd0);
    chk("rst_out_round", 32'(out_round), 32'd0);
    chk("rst_out_word",  out_word,       32'd0);
  endtask

  function automatic logic [31:0] abc_known(input int t);
    case (t)
      0:       return 32'h61626380;
      15:      return 32'h00000018;
      16:      return 32'h61626380;
      17:      return 32'h000F0000;
      18:      return 32'h7DA86405;
      default: return 32'h0;
    endcase
  endfunction

  // One block: load (optional gap / abort), then emit (optional backpressure / abort)
  task automatic run_block(input bit is_abc, input int gap_at, input int gap_len,
                           input bit bp, input int abort_load, input int abort_round);
    int idx, gapc, n, cyc, last0;
    build_model();
    last0 = last_cnt;
    idx = 0; gapc = 0;
    while (idx < 16) begin
      @(negedge clk);
      chk("load_in_ready",  32'(in_ready),  32'd1);
      chk("load_out_valid", 32'(out_valid), 32'd0);
      if (idx == abort_load) begin
        do_reset();
        return;
      end
      out_ready = 1'($urandom_range(0, 1));
      if (idx == gap_at && gapc < gap_len) begin
        in_valid = 1'b0; in_word = $urandom; gapc++;
      end else begin
        in_valid = 1'b1; in_word = blk[idx]; idx++;
      end
    end
    n = 0; cyc = 0;
    while (n < 64 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      chk("emit_valid",    32'(out_valid), 32'd1);
      chk("emit_in_ready", 32'(in_ready),  32'd0);
      chk("emit_busy",     32'(busy),      32'd1);
      chk("emit_round",    32'(out_round), 32'(n));
      chk("emit_word",     out_word,       expw[n]);
      chk("emit_last",     32'(out_last),  32'(n == 63));
      if (is_abc && (n <= 0 || (n >= 15 && n <= 18)))
        chk("abc_known", out_word, abc_known(n));
      if (n == abort_round) begin
        do_reset();
        return;
      end
      in_valid  = 1'($urandom_range(0, 1));
      in_word   = $urandom;
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready) dut_hs++;
      if (out_valid && out_ready && out_last) last_cnt++;
      if (out_ready) n++;
    end
    chk("emit_budget", 32'(n), 32'd64);
    chk("last_count", 32'(last_cnt - last0), 32'd1);
  endtask

  initial begin
    int hs0;
    @(negedge clk);
    @(negedge clk);
    chk("init_out_valid", 32'(out_valid), 32'd0);
    chk("init_busy",      32'(busy),      32'd0);
    chk("init_word",      out_word,       32'd0);
    chk("init_round",     32'(out_round), 32'd0);
    rst_n = 1'b1;

    set_abc();  run_block(1'b1, -1, 0, 1'b0, -1, -1);
    set_abc();  run_block(1'b1, -1, 0, 1'b1, -1, -1);
    set_abc();  run_block(1'b1,  6, 3, 1'b0, -1, -1);
    set_abc();  run_block(1'b1, -1, 0, 1'b0,  8, -1);
    set_abc();  run_block(1'b1, -1, 0, 1'b0, -1, -1);
    set_abc();  run_block(1'b1, -1, 0, 1'b1, -1, 30);
    set_abc();  run_block(1'b1, -1, 0, 1'b0, -1, -1);

    hs0 = dut_hs;
    set_abc();  run_block(1'b1, -1, 0, 1'b0, -1, -1);
    set_ff();   run_block(1'b0, -1, 0, 1'b0, -1, -1);
    chk("b2b_handshakes", 32'(dut_hs - hs0), 32'd128);

    for (int k = 0; k < 3; k++) begin
      set_rand(); run_block(1'b0, int'($urandom_range(1, 15)), int'($urandom_range(0, 4)), 1'b1, -1, -1);
    end

    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    chk("end_in_ready",  32'(in_ready),  32'd1);
    chk("end_out_valid", 32'(out_valid), 32'd0);
    chk("end_busy",      32'(busy),      32'd0);
    chk("end_out_last",  32'(out_last),  32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
